// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer code path.
// - N_BITS_DEF / thermo_width(): binary width default and the derived
//   thermometer width (2**N-1).
// - state_t: qualification state of the decoder (TRACK / LOCKED).
// - popcount() / is_thermo(): operate on a zero-extended word of
//   THERMO_MAX_W bits. Zero extension changes neither the ones count nor
//   legality, so any N_BITS up to N_BITS_MAX can share them.
package thermo_pkg;

    localparam int N_BITS_DEF   = 4;
    localparam int N_BITS_MAX   = 7;
    localparam int THERMO_MAX_W = (32'sd1 <<< N_BITS_MAX) - 32'sd1;
    localparam int PC_W         = 8;

    typedef enum logic {
        TRACK  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int thermo_width(input int n);
        return (32'sd1 <<< n) - 32'sd1;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [THERMO_MAX_W-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < THERMO_MAX_W; i++) begin
            n = n + {{(PC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // A thermometer word is a contiguous run of ones from bit 0, so adding
    // one carries through the whole run and leaves no overlap with v.
    function automatic logic is_thermo(input logic [THERMO_MAX_W-1:0] v);
        return ((v & (v + THERMO_MAX_W'(1))) == {THERMO_MAX_W{1'b0}});
    endfunction

endpackage

// File: rtl/thermo_check.sv
// Combinational thermometer word analysis.
// Ports:
//   s      in   THERMO_W  synchronized thermometer word
//   ones   out  N_BITS    number of set bits (bubble-corrected value)
//   legal  out  1         1 = s is a legal thermometer code
module thermo_check
    import thermo_pkg::*;
#(
    parameter  int N_BITS   = N_BITS_DEF,
    localparam int THERMO_W = thermo_width(N_BITS)
) (
    input  logic [THERMO_W-1:0] s,
    output logic [N_BITS-1:0]   ones,
    output logic                legal
);

    logic [THERMO_MAX_W-1:0] s_ext_s;
    logic [PC_W-1:0]         pc_s;

    // Ones count and legality of the current word.
    always_comb begin
        s_ext_s = THERMO_MAX_W'(s);
        pc_s    = popcount(s_ext_s);
        ones    = pc_s[N_BITS-1:0];
        // The count never exceeds THERMO_W, so the bits above N_BITS are
        // zero; folding them in keeps the truncation self-consistent.
        legal   = is_thermo(s_ext_s) && (pc_s[PC_W-1:N_BITS] == {(PC_W-N_BITS){1'b0}});
    end

endmodule

// File: rtl/thermo_decoder.sv
// Thermometer-to-binary decoder (receive side of the thermo_code path).
// Synchronizes an asynchronous thermometer word, requires it to be stable
// for STABLE_TICKS en_clk samples, then publishes its ones count.
// Ports:
//   clk         in   1         system clock
//   reset       in   1         synchronous active-high reset
//   en_clk      in   1         sampling strobe from freq_divider
//   thermo_in   in   THERMO_W  async thermometer word (k ones from LSB = k)
//   count       out  N_BITS    registered decoded value
//   upd         out  1         one-clk pulse when count/bubble_err are published
//   bubble_err  out  1         last accepted word was not a legal code
//   locked      out  1         1 = input accepted and stable, 0 = qualifying
module thermo_decoder
    import thermo_pkg::*;
#(
    parameter  int N_BITS       = N_BITS_DEF,
    parameter  int STABLE_TICKS = 3,
    parameter  bit CORRECT      = 1'b1,
    localparam int THERMO_W     = thermo_width(N_BITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_clk,
    input  logic [THERMO_W-1:0] thermo_in,
    output logic [N_BITS-1:0]   count,
    output logic                upd,
    output logic                bubble_err,
    output logic                locked
);

    localparam int               CNT_W    = $clog2(STABLE_TICKS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [THERMO_W-1:0] sync1_r;
    logic [THERMO_W-1:0] s_r;
    logic [THERMO_W-1:0] prev_r;
    logic [THERMO_W-1:0] prev_s;
    // Word most recently accepted; re-accepting it after a glitch restores
    // locked without announcing an update.
    logic [THERMO_W-1:0] acc_r;
    logic [THERMO_W-1:0] acc_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    state_t              state_r;
    state_t              state_s;
    logic [N_BITS-1:0]   count_r;
    logic [N_BITS-1:0]   count_s;
    logic                upd_r;
    logic                upd_s;
    logic                bubble_err_r;
    logic                bubble_err_s;
    logic                locked_r;
    logic                locked_s;
    logic [N_BITS-1:0]   ones_s;
    logic                legal_s;

    thermo_check #(
        .N_BITS (N_BITS)
    ) u_check (
        .s     (s_r),
        .ones  (ones_s),
        .legal (legal_s)
    );

    // Two-flop synchronizer, free-running on every clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= {THERMO_W{1'b0}};
            s_r     <= {THERMO_W{1'b0}};
        end else begin
            sync1_r <= thermo_in;
            s_r     <= sync1_r;
        end
    end

    // Qualification FSM next-state and output values.
    always_comb begin
        state_s      = state_r;
        prev_s       = prev_r;
        acc_s        = acc_r;
        cnt_s        = cnt_r;
        count_s      = count_r;
        bubble_err_s = bubble_err_r;
        locked_s     = locked_r;
        upd_s        = 1'b0;

        if (en_clk) begin
            if (s_r != prev_r) begin
                // Any change restarts qualification from scratch.
                prev_s   = s_r;
                cnt_s    = {CNT_W{1'b0}};
                state_s  = TRACK;
                locked_s = 1'b0;
            end else begin
                case (state_r)
                    TRACK: begin
                        if (cnt_r < CNT_LAST) begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end else begin
                            state_s  = LOCKED;
                            locked_s = 1'b1;
                            if (s_r != acc_r) begin
                                acc_s        = s_r;
                                upd_s        = 1'b1;
                                bubble_err_s = ~legal_s;
                                if (legal_s || CORRECT) begin
                                    count_s = ones_s;
                                end else begin
                                    count_s = count_r;
                                end
                            end else begin
                                acc_s = acc_r;
                            end
                        end
                    end
                    LOCKED: begin
                        state_s = LOCKED;
                    end
                    default: begin
                        state_s  = LOCKED;
                        locked_s = 1'b1;
                    end
                endcase
            end
        end else begin
            upd_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= LOCKED;
            prev_r       <= {THERMO_W{1'b0}};
            acc_r        <= {THERMO_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            count_r      <= {N_BITS{1'b0}};
            upd_r        <= 1'b0;
            bubble_err_r <= 1'b0;
            locked_r     <= 1'b1;
        end else begin
            state_r      <= state_s;
            prev_r       <= prev_s;
            acc_r        <= acc_s;
            cnt_r        <= cnt_s;
            count_r      <= count_s;
            upd_r        <= upd_s;
            bubble_err_r <= bubble_err_s;
            locked_r     <= locked_s;
        end
    end

    assign count      = count_r;
    assign upd        = upd_r;
    assign bubble_err = bubble_err_r;
    assign locked     = locked_r;

endmodule

// File: tb/tb_thermo_decoder.sv
module tb_thermo_decoder;

    logic        clk;
    logic        reset;
    logic        en_clk;
    logic [14:0] thermo_in;
    logic [3:0]  count_c1;
    logic        upd_c1;
    logic        bub_c1;
    logic        locked_c1;
    logic [3:0]  count_c0;
    logic        upd_c0;
    logic        bub_c0;
    logic        locked_c0;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic       pulse_mode = 1'b0;
    logic [1:0] phase      = 2'd0;
    logic [3:0] last_c1    = 4'd0;
    logic [3:0] last_c0    = 4'd0;

    typedef struct {
        logic [14:0] thermo;
        logic        chg;
        logic [3:0]  cnt1;
        logic        bub1;
        logic [3:0]  cnt0;
        logic        bub0;
    } vec_t;

    vec_t vecs[9];

    thermo_decoder #(.N_BITS(4), .STABLE_TICKS(3), .CORRECT(1'b1)) dut (
        .clk(clk), .reset(reset), .en_clk(en_clk), .thermo_in(thermo_in),
        .count(count_c1), .upd(upd_c1), .bubble_err(bub_c1), .locked(locked_c1)
    );

    thermo_decoder #(.N_BITS(4), .STABLE_TICKS(3), .CORRECT(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .en_clk(en_clk), .thermo_in(thermo_in),
        .count(count_c0), .upd(upd_c0), .bubble_err(bub_c0), .locked(locked_c0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled and the next en_clk is set 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        en_clk = pulse_mode ? (phase == 2'd3) : 1'b1;
        phase  = phase + 2'd1;
    endtask

    task automatic apply_row(input int idx, input vec_t v);
        logic early_upd;
        early_upd = 1'b0;
        thermo_in = v.thermo;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (upd_c1 || upd_c0) early_upd = 1'b1;
        end
        chk($sformatf("row%0d_early_upd", idx), {31'd0, early_upd}, 32'd0);
        chk($sformatf("row%0d_mid_count_c1", idx), {28'd0, count_c1}, {28'd0, last_c1});
        chk($sformatf("row%0d_mid_count_c0", idx), {28'd0, count_c0}, {28'd0, last_c0});
        chk($sformatf("row%0d_mid_locked", idx), {31'd0, locked_c1}, {31'd0, ~v.chg});
        step();
        chk($sformatf("row%0d_count_c1", idx), {28'd0, count_c1}, {28'd0, v.cnt1});
        chk($sformatf("row%0d_bub_c1", idx), {31'd0, bub_c1}, {31'd0, v.bub1});
        chk($sformatf("row%0d_upd_c1", idx), {31'd0, upd_c1}, {31'd0, v.chg});
        chk($sformatf("row%0d_locked_c1", idx), {31'd0, locked_c1}, 32'd1);
        chk($sformatf("row%0d_count_c0", idx), {28'd0, count_c0}, {28'd0, v.cnt0});
        chk($sformatf("row%0d_bub_c0", idx), {31'd0, bub_c0}, {31'd0, v.bub0});
        chk($sformatf("row%0d_upd_c0", idx), {31'd0, upd_c0}, {31'd0, v.chg});
        step();
        chk($sformatf("row%0d_upd_pulse_end", idx), {31'd0, upd_c1}, 32'd0);
        last_c1 = v.cnt1;
        last_c0 = v.cnt0;
    endtask

    initial begin
        logic seen_upd;
        logic saw_low;
        logic bad_count;
        logic got;
        logic en_at;
        int   pulses;
        int   edges;

        vecs[0] = '{15'h007F, 1'b1, 4'd7,  1'b0, 4'd7,  1'b0};
        vecs[1] = '{15'h005F, 1'b1, 4'd6,  1'b1, 4'd7,  1'b1};
        vecs[2] = '{15'h007F, 1'b1, 4'd7,  1'b0, 4'd7,  1'b0};
        vecs[3] = '{15'h7FFF, 1'b1, 4'd15, 1'b0, 4'd15, 1'b0};
        vecs[4] = '{15'h0000, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0};
        vecs[5] = '{15'h0001, 1'b1, 4'd1,  1'b0, 4'd1,  1'b0};
        vecs[6] = '{15'h0001, 1'b0, 4'd1,  1'b0, 4'd1,  1'b0};
        vecs[7] = '{15'h4000, 1'b1, 4'd1,  1'b1, 4'd1,  1'b1};
        vecs[8] = '{15'h0FFF, 1'b1, 4'd12, 1'b0, 4'd12, 1'b0};

        // Reset state.
        reset     = 1'b1;
        en_clk    = 1'b1;
        thermo_in = 15'h0000;
        repeat (3) step();
        chk("rst_count", {28'd0, count_c1}, 32'd0);
        chk("rst_upd", {31'd0, upd_c1}, 32'd0);
        chk("rst_bub", {31'd0, bub_c1}, 32'd0);
        chk("rst_locked", {31'd0, locked_c1}, 32'd1);
        reset = 1'b0;
        seen_upd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (upd_c1 || upd_c0) seen_upd = 1'b1;
        end
        chk("post_rst_no_upd", {31'd0, seen_upd}, 32'd0);
        chk("post_rst_locked", {31'd0, locked_c1}, 32'd1);

        // Table of directed words.
        for (int i = 0; i < 9; i++) begin
            apply_row(i, vecs[i]);
        end

        // Back to 7, then a 2-clk glitch to 0xFF.
        apply_row(9, vecs[0]);
        thermo_in = 15'h00FF;
        step();
        step();
        thermo_in = 15'h007F;
        seen_upd  = 1'b0;
        saw_low   = 1'b0;
        bad_count = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (upd_c1) seen_upd = 1'b1;
            if (!locked_c1) saw_low = 1'b1;
            if (count_c1 != 4'd7) bad_count = 1'b1;
        end
        chk("glitch_no_upd", {31'd0, seen_upd}, 32'd0);
        chk("glitch_locked_dropped", {31'd0, saw_low}, 32'd1);
        chk("glitch_locked_back", {31'd0, locked_c1}, 32'd1);
        chk("glitch_count_hold", {31'd0, bad_count}, 32'd0);
        chk("glitch_bub", {31'd0, bub_c1}, 32'd0);

        // en_clk pulsing 1-in-4: change to 0x0003.
        pulse_mode = 1'b1;
        phase      = 2'd0;
        en_clk     = 1'b0;
        thermo_in  = 15'h0003;
        got        = 1'b0;
        pulses     = 0;
        edges      = 0;
        bad_count  = 1'b0;
        while (!got && edges < 40) begin
            en_at = en_clk;
            step();
            edges++;
            if (edges >= 3 && en_at) pulses++;
            if (upd_c1) begin
                got = 1'b1;
                chk("en_upd_on_en_edge", {31'd0, en_at}, 32'd1);
                chk("en_pulses_to_upd", pulses, 32'd4);
                chk("en_count", {28'd0, count_c1}, 32'd2);
            end else if (count_c1 != 4'd7) begin
                bad_count = 1'b1;
            end
        end
        chk("en_upd_seen", {31'd0, got}, 32'd1);
        chk("en_count_held", {31'd0, bad_count}, 32'd0);
        pulse_mode = 1'b0;
        step();
        step();

        // Reset in the middle of TRACK toward 0x001F.
        thermo_in = 15'h001F;
        repeat (4) step();
        chk("rtrk_locked_low", {31'd0, locked_c1}, 32'd0);
        reset     = 1'b1;
        thermo_in = 15'h0000;
        step();
        chk("rtrk_count", {28'd0, count_c1}, 32'd0);
        chk("rtrk_count_nc", {28'd0, count_c0}, 32'd0);
        chk("rtrk_locked", {31'd0, locked_c1}, 32'd1);
        chk("rtrk_upd", {31'd0, upd_c1}, 32'd0);
        chk("rtrk_bub", {31'd0, bub_c1}, 32'd0);
        reset    = 1'b0;
        seen_upd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (upd_c1 || upd_c0) seen_upd = 1'b1;
        end
        chk("rtrk_no_later_upd", {31'd0, seen_upd}, 32'd0);
        chk("rtrk_still_locked", {31'd0, locked_c1}, 32'd1);
        chk("rtrk_count_stays", {28'd0, count_c1}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
